// File: rtl/frame_obj_pkg.sv
// Shared constants, object codes and BCD converter state for the frame object mapper.
package frame_obj_pkg;

  localparam int NUM_FLOORS = 8;
  localparam int COORD_W    = 10;
  localparam int DOODLE_W   = 32;
  localparam int DOODLE_H   = 32;
  localparam int FLOOR_W    = 60;
  localparam int FLOOR_H    = 10;
  localparam int NUM_OBJS   = NUM_FLOORS + 1;

  // Sprite sizes widened to the 11-bit difference width used by the hit test.
  localparam logic [COORD_W:0] DOODLE_W_EXT = (COORD_W + 1)'(DOODLE_W);
  localparam logic [COORD_W:0] DOODLE_H_EXT = (COORD_W + 1)'(DOODLE_H);
  localparam logic [COORD_W:0] FLOOR_W_EXT  = (COORD_W + 1)'(FLOOR_W);
  localparam logic [COORD_W:0] FLOOR_H_EXT  = (COORD_W + 1)'(FLOOR_H);

  localparam logic [1:0] OBJ_NONE   = 2'd0;
  localparam logic [1:0] OBJ_DOODLE = 2'd1;
  localparam logic [1:0] OBJ_FLOOR  = 2'd2;

  typedef enum logic [1:0] {
    BCD_IDLE,
    BCD_LOAD,
    BCD_SHIFT,
    BCD_DONE
  } bcd_state_e;

  // Double-dabble correction: every BCD digit >= 5 gets +3 before the shift.
  function automatic logic [19:0] dabble_adjust(input logic [19:0] acc);
    logic [19:0] r;
    r = acc;
    for (int d = 0; d < 5; d++) begin
      if (acc[d*4 +: 4] >= 4'd5) r[d*4 +: 4] = acc[d*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/frame_object_mapper_bin2bcd.sv
// Sequential 16-bit to 5-digit BCD converter (double dabble, one bit per cycle).
// start_i is accepted whenever busy_o is low, including the DONE cycle.
module bin2bcd_seq
  import frame_obj_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [15:0] bin_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [19:0] bcd_o
);

  bcd_state_e  state_q;
  logic [15:0] work_q;
  logic [19:0] acc_q;
  logic [3:0]  cnt_q;
  logic [19:0] bcd_q;
  logic        done_q;
  logic [35:0] shifted_d;

  assign shifted_d = {dabble_adjust(acc_q), work_q} << 1;

  // NOTE: sequential state is written with <= only, so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BCD_IDLE;
      work_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        BCD_IDLE: begin
          if (start_i) state_q <= BCD_LOAD;
        end
        BCD_LOAD: begin
          work_q  <= bin_i;
          acc_q   <= '0;
          cnt_q   <= '0;
          state_q <= BCD_SHIFT;
        end
        BCD_SHIFT: begin
          acc_q  <= shifted_d[35:16];
          work_q <= shifted_d[15:0];
          cnt_q  <= cnt_q + 4'd1;
          // Result and pulse are registered on the last shift so they appear in DONE.
          if (cnt_q == 4'd15) begin
            bcd_q   <= shifted_d[35:16];
            done_q  <= 1'b1;
            state_q <= BCD_DONE;
          end
        end
        BCD_DONE: begin
          state_q <= start_i ? BCD_LOAD : BCD_IDLE;
        end
        default: state_q <= BCD_IDLE;
      endcase
    end
  end

  assign busy_o = (state_q == BCD_LOAD) || (state_q == BCD_SHIFT);
  assign done_o = done_q;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/frame_object_mapper.sv
// Per-frame coordinate shadowing, 2-stage pixel hit test and score-to-BCD conversion
// for the doodle/platform sprite renderer.
module frame_object_mapper
  import frame_obj_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          frame_start_i,
  input  logic [COORD_W-1:0]            doodle_x_i,
  input  logic [COORD_W-1:0]            doodle_y_i,
  input  logic [NUM_FLOORS*COORD_W-1:0] floor_x_i,
  input  logic [NUM_FLOORS*COORD_W-1:0] floor_y_i,
  input  logic [15:0]                   score_i,
  input  logic                          pix_valid_i,
  input  logic [COORD_W-1:0]            draw_x_i,
  input  logic [COORD_W-1:0]            draw_y_i,
  output logic                          obj_valid_o,
  output logic [1:0]                    obj_code_o,
  output logic [2:0]                    obj_idx_o,
  output logic [5:0]                    rel_x_o,
  output logic [5:0]                    rel_y_o,
  output logic [19:0]                   score_bcd_o,
  output logic                          bcd_done_o
);

  logic [COORD_W-1:0]            doodle_x_q, doodle_y_q;
  logic [NUM_FLOORS*COORD_W-1:0] floor_x_q, floor_y_q;
  logic [15:0]                   score_q;
  logic                          loaded_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      doodle_x_q <= '0;
      doodle_y_q <= '0;
      floor_x_q  <= '0;
      floor_y_q  <= '0;
      score_q    <= '0;
      loaded_q   <= 1'b0;
    end else if (frame_start_i) begin
      doodle_x_q <= doodle_x_i;
      doodle_y_q <= doodle_y_i;
      floor_x_q  <= floor_x_i;
      floor_y_q  <= floor_y_i;
      score_q    <= score_i;
      loaded_q   <= 1'b1;
    end
  end

  // Stage 1: per-object offset and bounds test; object 0 is the doodle, 1..8 the floors.
  logic [NUM_OBJS-1:0]      hit_d;
  logic [NUM_OBJS-1:0][5:0] rx_d, ry_d;
  logic [COORD_W-1:0]       ox, oy;
  logic [COORD_W:0]         dx, dy, w, h;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    hit_d = '0;
    rx_d  = '0;
    ry_d  = '0;
    ox    = '0;
    oy    = '0;
    dx    = '0;
    dy    = '0;
    w     = '0;
    h     = '0;
    for (int i = 0; i < NUM_OBJS; i++) begin
      if (i == 0) begin
        ox = doodle_x_q;
        oy = doodle_y_q;
        w  = DOODLE_W_EXT;
        h  = DOODLE_H_EXT;
      end else begin
        ox = floor_x_q[(i-1)*COORD_W +: COORD_W];
        oy = floor_y_q[(i-1)*COORD_W +: COORD_W];
        w  = FLOOR_W_EXT;
        h  = FLOOR_H_EXT;
      end
      dx = {1'b0, draw_x_i} - {1'b0, ox};
      dy = {1'b0, draw_y_i} - {1'b0, oy};
      hit_d[i] = loaded_q && pix_valid_i && !dx[COORD_W] && !dy[COORD_W]
                 && (dx < w) && (dy < h);
      rx_d[i]  = dx[5:0];
      ry_d[i]  = dy[5:0];
    end
  end

  logic                     s1_valid_q;
  logic [NUM_OBJS-1:0]      s1_hit_q;
  logic [NUM_OBJS-1:0][5:0] s1_rx_q, s1_ry_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_hit_q   <= '0;
      s1_rx_q    <= '0;
      s1_ry_q    <= '0;
    end else begin
      s1_valid_q <= pix_valid_i;
      s1_hit_q   <= hit_d;
      s1_rx_q    <= rx_d;
      s1_ry_q    <= ry_d;
    end
  end

  // Stage 2: priority select; descending scan lets the lowest floor win, doodle overrides all.
  logic [1:0] code_d;
  logic [2:0] idx_d;
  logic [5:0] rel_x_d, rel_y_d;

  always_comb begin
    code_d  = OBJ_NONE;
    idx_d   = '0;
    rel_x_d = '0;
    rel_y_d = '0;
    for (int i = NUM_OBJS - 1; i >= 1; i--) begin
      if (s1_hit_q[i]) begin
        code_d  = OBJ_FLOOR;
        idx_d   = 3'(i - 1);
        rel_x_d = s1_rx_q[i];
        rel_y_d = s1_ry_q[i];
      end
    end
    if (s1_hit_q[0]) begin
      code_d  = OBJ_DOODLE;
      idx_d   = '0;
      rel_x_d = s1_rx_q[0];
      rel_y_d = s1_ry_q[0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      obj_valid_o <= 1'b0;
      obj_code_o  <= OBJ_NONE;
      obj_idx_o   <= '0;
      rel_x_o     <= '0;
      rel_y_o     <= '0;
    end else begin
      obj_valid_o <= s1_valid_q;
      obj_code_o  <= code_d;
      obj_idx_o   <= idx_d;
      rel_x_o     <= rel_x_d;
      rel_y_o     <= rel_y_d;
    end
  end

  // A frame_start arriving mid-conversion is remembered and replayed from the DONE cycle.
  logic bcd_busy, bcd_start, pending_q, pending_d;

  assign bcd_start = frame_start_i | pending_q;

  always_comb begin
    pending_d = pending_q;
    if (bcd_start && !bcd_busy) pending_d = 1'b0;
    if (frame_start_i && bcd_busy) pending_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending_q <= 1'b0;
    else     pending_q <= pending_d;
  end

  bin2bcd_seq u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .start_i (bcd_start),
    .bin_i   (score_q),
    .busy_o  (bcd_busy),
    .done_o  (bcd_done_o),
    .bcd_o   (score_bcd_o)
  );

endmodule

// File: tb/tb_frame_object_mapper.sv
// Directed self-checking bench for frame_object_mapper: pixel vector tables plus
// hand-written frame-swap, BCD timing, back-to-back and reset sequences.
module tb_frame_object_mapper;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic [9:0]  doodle_x = '0, doodle_y = '0;
  logic [79:0] floor_x = '0, floor_y = '0;
  logic [15:0] score = '0;
  logic        pix_valid = 1'b0;
  logic [9:0]  draw_x = '0, draw_y = '0;
  logic        obj_valid;
  logic [1:0]  obj_code;
  logic [2:0]  obj_idx;
  logic [5:0]  rel_x, rel_y;
  logic [19:0] score_bcd;
  logic        bcd_done;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [9:0] px;
    logic [9:0] py;
    logic [1:0] code;
    logic [2:0] idx;
    logic [5:0] rx;
    logic [5:0] ry;
  } pix_vec_t;

  pix_vec_t vecs[$];

  frame_object_mapper dut (
    .clk           (clk),
    .rst           (rst),
    .frame_start_i (frame_start),
    .doodle_x_i    (doodle_x),
    .doodle_y_i    (doodle_y),
    .floor_x_i     (floor_x),
    .floor_y_i     (floor_y),
    .score_i       (score),
    .pix_valid_i   (pix_valid),
    .draw_x_i      (draw_x),
    .draw_y_i      (draw_y),
    .obj_valid_o   (obj_valid),
    .obj_code_o    (obj_code),
    .obj_idx_o     (obj_idx),
    .rel_x_o       (rel_x),
    .rel_y_o       (rel_y),
    .score_bcd_o   (score_bcd),
    .bcd_done_o    (bcd_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Drives new coordinates and pulses frame_start for one cycle.
  task automatic load_frame(input logic [9:0] dxv, input logic [9:0] dyv,
                            input logic [79:0] fx, input logic [79:0] fy,
                            input logic [15:0] sc);
    doodle_x    = dxv;
    doodle_y    = dyv;
    floor_x     = fx;
    floor_y     = fy;
    score       = sc;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  // Pixels back-to-back; results of pixel t are checked two cycles later.
  task automatic run_vecs(input string tag);
    int n;
    n = vecs.size();
    for (int t = 0; t < n + 2; t++) begin
      if (t < n) begin
        pix_valid = 1'b1;
        draw_x    = vecs[t].px;
        draw_y    = vecs[t].py;
      end else begin
        pix_valid = 1'b0;
      end
      if (t >= 2) begin
        check($sformatf("%s[%0d] valid", tag, t - 2), {31'd0, obj_valid}, 32'd1);
        check($sformatf("%s[%0d] code/idx/rel", tag, t - 2),
              {12'd0, obj_code, obj_idx, rel_x, rel_y},
              {12'd0, vecs[t-2].code, vecs[t-2].idx, vecs[t-2].rx, vecs[t-2].ry});
      end
      step();
    end
    pix_valid = 1'b0;
    vecs.delete();
  endtask

  // Conversion started in the current cycle (cycle 0); result expected in cycle 18.
  task automatic bcd_run(input logic [15:0] sc, input logic [19:0] expv, input logic [19:0] prev);
    int early;
    early       = 0;
    score       = sc;
    frame_start = 1'b1;
    for (int c = 1; c <= 19; c++) begin
      step();
      frame_start = 1'b0;
      if (c < 18 && bcd_done) early++;
      if (c == 10) check($sformatf("bcd %0d hold", sc), {12'd0, score_bcd}, {12'd0, prev});
      if (c == 18) begin
        check($sformatf("bcd %0d done", sc), {31'd0, bcd_done}, 32'd1);
        check($sformatf("bcd %0d value", sc), {12'd0, score_bcd}, {12'd0, expv});
      end
      if (c == 19) check($sformatf("bcd %0d pulse width", sc), {31'd0, bcd_done}, 32'd0);
    end
    check($sformatf("bcd %0d early done", sc), early, 0);
  endtask

  initial begin
    logic [79:0] fx, fy;
    int          extra;

    do_reset();
    check("reset obj outputs", {11'd0, obj_valid, obj_code, obj_idx, rel_x, rel_y}, 32'd0);
    check("reset bcd outputs", {11'd0, bcd_done, score_bcd}, 32'd0);

    // Pixel before any frame_start: valid but no object even though shadows sit at (0,0).
    pix_valid = 1'b1;
    draw_x    = 10'd0;
    draw_y    = 10'd0;
    step();
    pix_valid = 1'b0;
    check("unloaded n+1 valid", {31'd0, obj_valid}, 32'd0);
    step();
    check("unloaded n+2 valid", {31'd0, obj_valid}, 32'd1);
    check("unloaded code", {30'd0, obj_code}, 32'd0);
    step();
    check("unloaded n+3 valid", {31'd0, obj_valid}, 32'd0);

    // Frame A: doodle (100,200), floor1 (500,100), floor3 (90,210), floor8 (700,300).
    fx = {8{10'd1000}};
    fy = {8{10'd1000}};
    fx[0*10 +: 10] = 10'd500; fy[0*10 +: 10] = 10'd100;
    fx[2*10 +: 10] = 10'd90;  fy[2*10 +: 10] = 10'd210;
    fx[7*10 +: 10] = 10'd700; fy[7*10 +: 10] = 10'd300;
    load_frame(10'd100, 10'd200, fx, fy, 16'd0);
    vecs.push_back('{10'd100, 10'd200, 2'd1, 3'd0, 6'd0,  6'd0});
    vecs.push_back('{10'd131, 10'd231, 2'd1, 3'd0, 6'd31, 6'd31});
    vecs.push_back('{10'd132, 10'd200, 2'd0, 3'd0, 6'd0,  6'd0});
    vecs.push_back('{10'd100, 10'd232, 2'd0, 3'd0, 6'd0,  6'd0});
    vecs.push_back('{10'd99,  10'd200, 2'd0, 3'd0, 6'd0,  6'd0});
    vecs.push_back('{10'd105, 10'd212, 2'd1, 3'd0, 6'd5,  6'd12});
    vecs.push_back('{10'd95,  10'd215, 2'd2, 3'd2, 6'd5,  6'd5});
    vecs.push_back('{10'd150, 10'd215, 2'd0, 3'd0, 6'd0,  6'd0});
    vecs.push_back('{10'd149, 10'd219, 2'd2, 3'd2, 6'd59, 6'd9});
    vecs.push_back('{10'd500, 10'd100, 2'd2, 3'd0, 6'd0,  6'd0});
    vecs.push_back('{10'd559, 10'd109, 2'd2, 3'd0, 6'd59, 6'd9});
    vecs.push_back('{10'd500, 10'd110, 2'd0, 3'd0, 6'd0,  6'd0});
    vecs.push_back('{10'd710, 10'd305, 2'd2, 3'd7, 6'd10, 6'd5});
    run_vecs("frameA");

    // Frame B: floor3 and floor5 overlap at (300,400); doodle at origin.
    fx = {8{10'd1000}};
    fy = {8{10'd1000}};
    fx[2*10 +: 10] = 10'd300; fy[2*10 +: 10] = 10'd400;
    fx[4*10 +: 10] = 10'd300; fy[4*10 +: 10] = 10'd400;
    load_frame(10'd0, 10'd0, fx, fy, 16'd0);
    vecs.push_back('{10'd310, 10'd405, 2'd2, 3'd2, 6'd10, 6'd5});
    vecs.push_back('{10'd5,   10'd5,   2'd1, 3'd0, 6'd5,  6'd5});
    vecs.push_back('{10'd359, 10'd409, 2'd2, 3'd2, 6'd59, 6'd9});
    vecs.push_back('{10'd32,  10'd0,   2'd0, 3'd0, 6'd0,  6'd0});
    run_vecs("frameB");

    // Frame swap: the pixel in the frame_start cycle still sees the old doodle.
    fx = {8{10'd1000}};
    fy = {8{10'd1000}};
    load_frame(10'd100, 10'd200, fx, fy, 16'd0);
    doodle_x    = 10'd400;
    doodle_y    = 10'd400;
    frame_start = 1'b1;
    pix_valid   = 1'b1;
    draw_x      = 10'd100;
    draw_y      = 10'd200;
    step();
    frame_start = 1'b0;
    step();
    pix_valid = 1'b0;
    check("swap old frame code", {30'd0, obj_code}, 32'd1);
    step();
    check("swap new frame code", {30'd0, obj_code}, 32'd0);
    check("swap new frame valid", {31'd0, obj_valid}, 32'd1);

    // Score conversions from a clean, idle converter.
    do_reset();
    bcd_run(16'd65535, 20'h65535, 20'h00000);
    bcd_run(16'd0,     20'h00000, 20'h65535);
    bcd_run(16'd9,     20'h00009, 20'h00000);

    // Back-to-back: second frame_start at cycle 5 is converted after the first finishes.
    extra       = 0;
    score       = 16'd42;
    frame_start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      step();
      frame_start = (c == 5);
      if (c == 5) score = 16'd1234;
      if (c == 18) begin
        check("b2b first done", {31'd0, bcd_done}, 32'd1);
        check("b2b first value", {12'd0, score_bcd}, 32'h00042);
      end else if (c == 36) begin
        check("b2b second done", {31'd0, bcd_done}, 32'd1);
        check("b2b second value", {12'd0, score_bcd}, 32'h01234);
      end else if (bcd_done) begin
        extra++;
      end
      if (c == 30) check("b2b hold", {12'd0, score_bcd}, 32'h00042);
    end
    check("b2b stray done", extra, 0);

    // Reset at cycle 10 of a conversion: outputs clear at once, no done follows.
    score       = 16'd999;
    frame_start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      frame_start = 1'b0;
    end
    #2;
    rst = 1'b1;
    #1;
    check("mid reset obj outputs", {11'd0, obj_valid, obj_code, obj_idx, rel_x, rel_y}, 32'd0);
    check("mid reset bcd outputs", {11'd0, bcd_done, score_bcd}, 32'd0);
    step();
    rst   = 1'b0;
    extra = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (bcd_done) extra++;
    end
    check("mid reset no done", extra, 0);
    check("mid reset bcd stays 0", {12'd0, score_bcd}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
